// File: rtl/memory_arb2_pkg.sv
// Shared definitions for memory_arb2: arbitration policy codes, channel pointer
// encoding and the byte-lane count helper.
package memory_pkg;

    localparam int PRIO_ROUND_ROBIN = 0;
    localparam int PRIO_FIXED_A     = 1;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } ch_e;

    function automatic int lane_count(input int bits);
        return bits / 8;
    endfunction

    localparam int DEFAULT_BITS  = 16;
    localparam int DEFAULT_LANES = lane_count(DEFAULT_BITS);

endpackage

// File: rtl/memory_arb2_if.sv
// One request channel of memory_arb2: request/write bus from the master, grant
// and registered read return from the arbiter.
interface memory_arb2_if
    import memory_pkg::*;
#(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 15
) ();

    logic                        req;
    logic                        wr;
    logic [ADDRESS_BITS-1:0]     address;
    logic [BITS-1:0]             data_in;
    logic [lane_count(BITS)-1:0] be;
    logic                        gnt;
    logic [BITS-1:0]             data_out;
    logic                        valid;

    modport master (
        output req, wr, address, data_in, be,
        input  gnt, data_out, valid
    );

    modport slave (
        input  req, wr, address, data_in, be,
        output gnt, data_out, valid
    );

endinterface

// File: rtl/memory_arb2_arbiter.sv
// Two-way combinational grant with a last-grant pointer; round-robin or fixed
// A priority selected by PRIORITY_MODE.
module memory_arb2_arbiter
    import memory_pkg::*;
#(
    parameter int PRIORITY_MODE = PRIO_ROUND_ROBIN
) (
    input  logic clk,
    input  logic rst,
    input  logic a_req,
    input  logic b_req,
    output logic a_gnt,
    output logic b_gnt
);

    ch_e last_q;
    ch_e last_d;

    // Pointer starts at B so A wins the first contested cycle after reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // sample pre-edge values regardless of process ordering.
        if (rst) begin
            last_q <= CH_B;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        a_gnt  = 1'b0;
        b_gnt  = 1'b0;
        last_d = last_q;
        if (!rst) begin
            if (a_req && b_req) begin
                if (PRIORITY_MODE == PRIO_FIXED_A || last_q == CH_B) begin
                    a_gnt = 1'b1;
                end else begin
                    b_gnt = 1'b1;
                end
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
            if (a_gnt) begin
                last_d = CH_A;
            end else if (b_gnt) begin
                last_d = CH_B;
            end
        end
    end

endmodule

// File: rtl/memory_arb2.sv
// Dual-channel arbitrated single-port RAM with byte enables and read-valid strobe.
// Define MEMORY_ARB2_OUTREG_EN for an extra output register stage (2-cycle read).
module memory_arb2
    import memory_pkg::*;
#(
    parameter int BITS          = 16,
    parameter int ADDRESS_BITS  = 15,
    parameter int PRIORITY_MODE = PRIO_ROUND_ROBIN
) (
    input  logic          CLK,
    input  logic          RESET,
    memory_arb2_if.slave  a,
    memory_arb2_if.slave  b
);

    localparam int LANES = lane_count(BITS);
    localparam int DEPTH = 2 ** ADDRESS_BITS;

    logic a_gnt;
    logic b_gnt;

    memory_arb2_arbiter #(
        .PRIORITY_MODE (PRIORITY_MODE)
    ) u_arbiter (
        .clk   (CLK),
        .rst   (RESET),
        .a_req (a.req),
        .b_req (b.req),
        .a_gnt (a_gnt),
        .b_gnt (b_gnt)
    );

    assign a.gnt = a_gnt;
    assign b.gnt = b_gnt;

    logic                    acc_en;
    logic                    acc_b;
    logic                    acc_wr;
    logic [ADDRESS_BITS-1:0] acc_addr;
    logic [BITS-1:0]         acc_wdata;
    logic [LANES-1:0]        acc_be;
    logic [BITS-1:0]         rd_word;

    // The granted channel drives the single RAM port.
    always_comb begin
        acc_en    = a_gnt | b_gnt;
        acc_b     = b_gnt;
        acc_wr    = a.wr;
        acc_addr  = a.address;
        acc_wdata = a.data_in;
        acc_be    = a.be;
        if (b_gnt) begin
            acc_wr    = b.wr;
            acc_addr  = b.address;
            acc_wdata = b.data_in;
            acc_be    = b.be;
        end
    end

    logic [BITS-1:0] mem [DEPTH];

    // NOTE: the RAM array is intentionally not reset; only control and output
    // flops are, which keeps the array mappable onto block RAM.
    always_ff @(posedge CLK) begin
        if (acc_en && acc_wr) begin
            for (int i = 0; i < LANES; i++) begin
                if (acc_be[i]) begin
                    mem[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rd_word = mem[acc_addr];

    logic [BITS-1:0] dout_q  [2];
    logic [BITS-1:0] dout_d  [2];
    logic            valid_q [2];
    logic            valid_d [2];

    // Read data is captured only by the channel that was granted the read.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            dout_d[c]  = dout_q[c];
            valid_d[c] = 1'b0;
        end
        if (acc_en && !acc_wr) begin
            dout_d[acc_b]  = rd_word;
            valid_d[acc_b] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int c = 0; c < 2; c++) begin
                dout_q[c]  <= '0;
                valid_q[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                dout_q[c]  <= dout_d[c];
                valid_q[c] <= valid_d[c];
            end
        end
    end

    logic [BITS-1:0] dout_o  [2];
    logic            valid_o [2];

`ifdef MEMORY_ARB2_OUTREG_EN
    logic [BITS-1:0] dout2_q  [2];
    logic [BITS-1:0] dout2_d  [2];
    logic            valid2_q [2];
    logic            valid2_d [2];

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            valid2_d[c] = valid_q[c];
            dout2_d[c]  = valid_q[c] ? dout_q[c] : dout2_q[c];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int c = 0; c < 2; c++) begin
                dout2_q[c]  <= '0;
                valid2_q[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                dout2_q[c]  <= dout2_d[c];
                valid2_q[c] <= valid2_d[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            dout_o[c]  = dout2_q[c];
            valid_o[c] = valid2_q[c];
        end
    end
`else
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            dout_o[c]  = dout_q[c];
            valid_o[c] = valid_q[c];
        end
    end
`endif

    // Outputs read as reset values for the whole reset cycle, so a read in
    // flight when RESET rises is discarded rather than strobed.
    assign a.valid    = valid_o[0] & ~RESET;
    assign b.valid    = valid_o[1] & ~RESET;
    assign a.data_out = RESET ? '0 : dout_o[0];
    assign b.data_out = RESET ? '0 : dout_o[1];

endmodule
